// File: rtl/imem_word_writer_if.sv
// Request and memory-write bundle for imem_word_writer.
// The slave side is the writer; the master side is the loader or the bench.
interface imem_word_writer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_word;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              busy;
    logic              done;
    logic              err_align;
    logic [CNT_W-1:0]  word_count;

    modport slave (
        input  in_valid, in_addr, in_word,
        output in_ready, mem_we, mem_addr, mem_din, busy, done, err_align, word_count
    );

    modport master (
        output in_valid, in_addr, in_word,
        input  in_ready, mem_we, mem_addr, mem_din, busy, done, err_align, word_count
    );
endinterface

// File: rtl/imem_word_writer.sv
// Serialises 32-bit instruction words into four big-endian byte writes
// on the byte-wide instruction memory write port.
module imem_word_writer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_word_writer_if.slave  bus
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       word_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_din_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready;
    logic              accept;
    logic              aligned;

    assign k_d      = k_q + 2'd1;
    assign in_ready = (state_q == IDLE) || (k_q == 2'd3);
    assign accept   = bus.in_valid && in_ready;
    assign aligned  = (bus.in_addr[1:0] == 2'b00);

    // Outputs are loaded one edge ahead, so they always describe byte k_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            base_q     <= '0;
            word_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state_q == WRITE) begin
                if (k_q == 2'd3) begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    state_q  <= IDLE;
                    k_q      <= 2'd0;
                    mem_we_q <= 1'b0;
                end else begin
                    k_q        <= k_d;
                    mem_addr_q <= base_q + {{(ADDR_W-2){1'b0}}, k_d};
                    mem_din_q  <= word_q[8*(3-k_d) +: 8];
                    done_q     <= (k_d == 2'd3);
                end
            end
            // Accepts only happen in IDLE or at k==3, so this overrides the retire path.
            if (accept) begin
                if (aligned) begin
                    state_q    <= WRITE;
                    k_q        <= 2'd0;
                    base_q     <= bus.in_addr;
                    word_q     <= bus.in_word;
                    mem_we_q   <= 1'b1;
                    mem_addr_q <= bus.in_addr;
                    mem_din_q  <= bus.in_word[31:24];
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.busy       = (state_q == WRITE);
    assign bus.done       = done_q;
    assign bus.err_align  = err_q;
    assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_imem_word_writer.sv
// Directed bench for imem_word_writer: main instance plus a CNT_W=2 instance
// for counter saturation, each feeding a behavioural 256x8 array.
module tb_imem_word_writer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imem_word_writer_if #(.ADDR_W(8), .CNT_W(16)) bus ();
    imem_word_writer_if #(.ADDR_W(8), .CNT_W(2))  sbus ();

    imem_word_writer #(.ADDR_W(8), .CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    imem_word_writer #(.ADDR_W(8), .CNT_W(2))  u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

    logic [7:0] mem  [256];
    logic [7:0] smem [256];
    int we_cnt = 0;
    int swe_cnt = 0;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= 8'h5A;
                smem[i] <= 8'h5A;
            end
        end else begin
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_din;
                we_cnt <= we_cnt + 1;
            end
            if (sbus.mem_we) begin
                smem[sbus.mem_addr] <= sbus.mem_din;
                swe_cnt <= swe_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    function automatic logic [31:0] sfetch(input logic [7:0] a);
        return {smem[a], smem[a + 8'd1], smem[a + 8'd2], smem[a + 8'd3]};
    endfunction

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [7:0] a, input logic [31:0] w, input string tg);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_addr = a; bus.in_word = w;
        chk({tg, ".rdy0"}, {31'd0, bus.in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.in_valid = 1'b0;
            chk({tg, ".we"},   {31'd0, bus.mem_we}, 32'd1);
            chk({tg, ".addr"}, {24'd0, bus.mem_addr}, {24'd0, 8'(a + 8'(k))});
            chk({tg, ".din"},  {24'd0, bus.mem_din}, {24'd0, 8'(w >> (24 - 8 * k))});
            chk({tg, ".done"}, {31'd0, bus.done}, (k == 3) ? 32'd1 : 32'd0);
            chk({tg, ".rdy"},  {31'd0, bus.in_ready}, (k == 3) ? 32'd1 : 32'd0);
            chk({tg, ".busy"}, {31'd0, bus.busy}, 32'd1);
        end
        @(negedge clk);
        chk({tg, ".we_end"},   {31'd0, bus.mem_we}, 32'd0);
        chk({tg, ".busy_end"}, {31'd0, bus.busy}, 32'd0);
        chk({tg, ".done_end"}, {31'd0, bus.done}, 32'd0);
        chk({tg, ".fetch"},    fetch(a), w);
    endtask

    initial begin
        int we0;
        logic [1:0] sexp [5];
        bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_word = '0;
        sbus.in_valid = 1'b0; sbus.in_addr = '0; sbus.in_word = '0;
        @(negedge clk); @(negedge clk);
        clr = 1'b0;
        // Reset values
        chk("rst.rdy",  {31'd0, bus.in_ready}, 32'd1);
        chk("rst.we",   {31'd0, bus.mem_we}, 32'd0);
        chk("rst.addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rst.din",  {24'd0, bus.mem_din}, 32'd0);
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk("rst.err",  {31'd0, bus.err_align}, 32'd0);
        chk("rst.cnt",  {16'd0, bus.word_count}, 32'd0);
        rst_n = 1'b1;

        // Single aligned word
        send_word(8'h10, 32'hDEADBEEF, "w1");
        chk("w1.cnt", {16'd0, bus.word_count}, 32'd1);

        // Back-to-back, valid held high
        do_reset();
        we0 = we_cnt;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_addr = 8'h00; bus.in_word = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    if (i == 0)      begin bus.in_addr = 8'h04; bus.in_word = 32'h22222222; end
                    else if (i == 1) begin bus.in_addr = 8'h08; bus.in_word = 32'h33333333; end
                    else bus.in_valid = 1'b0;
                end
                chk("b2b.we",  {31'd0, bus.mem_we}, 32'd1);
                chk("b2b.rdy", {31'd0, bus.in_ready}, (k == 3) ? 32'd1 : 32'd0);
                chk("b2b.addr", {24'd0, bus.mem_addr}, 32'(4 * i + k));
            end
        end
        @(negedge clk);
        chk("b2b.we_end", {31'd0, bus.mem_we}, 32'd0);
        chk("b2b.ncyc", 32'(we_cnt - we0), 32'd12);
        chk("b2b.cnt", {16'd0, bus.word_count}, 32'd3);
        chk("b2b.m0", fetch(8'h00), 32'h11111111);
        chk("b2b.m4", fetch(8'h04), 32'h22222222);
        chk("b2b.m8", fetch(8'h08), 32'h33333333);

        // Misaligned request
        we0 = we_cnt;
        bus.in_valid = 1'b1; bus.in_addr = 8'h06; bus.in_word = 32'hCAFEF00D;
        chk("mis.rdy0", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mis.err",  {31'd0, bus.err_align}, 32'd1);
        chk("mis.we",   {31'd0, bus.mem_we}, 32'd0);
        chk("mis.rdy1", {31'd0, bus.in_ready}, 32'd1);
        chk("mis.busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("mis.err_end", {31'd0, bus.err_align}, 32'd0);
        chk("mis.nwe", 32'(we_cnt - we0), 32'd0);
        chk("mis.cnt", {16'd0, bus.word_count}, 32'd3);

        // Top of memory
        send_word(8'hFC, 32'h01020304, "top");
        chk("top.rdy", {31'd0, bus.in_ready}, 32'd1);

        // Reset during byte 2 of a word
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_addr = 8'h20; bus.in_word = 32'hA1B2C3D4;
        @(negedge clk); bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw.k2_done", {31'd0, bus.done}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rmw.we",   {31'd0, bus.mem_we}, 32'd0);
        chk("rmw.addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rmw.din",  {24'd0, bus.mem_din}, 32'd0);
        chk("rmw.busy", {31'd0, bus.busy}, 32'd0);
        chk("rmw.done", {31'd0, bus.done}, 32'd0);
        chk("rmw.rdy",  {31'd0, bus.in_ready}, 32'd1);
        chk("rmw.cnt",  {16'd0, bus.word_count}, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("rmw.mem", fetch(8'h20), 32'hA1B25A5A);
        rst_n = 1'b1;

        // Saturating counter on the CNT_W=2 instance
        sexp[0] = 2'd1; sexp[1] = 2'd2; sexp[2] = 2'd3; sexp[3] = 2'd3; sexp[4] = 2'd3;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            sbus.in_valid = 1'b1; sbus.in_addr = 8'(8'h40 + 4 * w);
            sbus.in_word = 32'h10203040 + 32'(w) * 32'h01010101;
            @(negedge clk); sbus.in_valid = 1'b0;
            repeat (4) @(negedge clk);
            chk("sat.cnt", {30'd0, sbus.word_count}, {30'd0, sexp[w]});
        end
        chk("sat.nwe", 32'(swe_cnt), 32'd20);
        for (int w = 0; w < 5; w++)
            chk("sat.mem", sfetch(8'(8'h40 + 4 * w)), 32'h10203040 + 32'(w) * 32'h01010101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
